// File: rtl/li_rr_merge_arbiter_pkg.sv
// Shared definitions for the round-robin merge arbiter.
// Provides the arbiter FSM state encoding and a constant clog2 helper
// used to validate the source-index width against the input count.
package li_rr_merge_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Ceiling log2 for elaboration-time width checks.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/li_skid_buffer_2slot.sv
// Two-slot output buffer: slot1 drives the output, slot2 absorbs one extra
// token so upstream can keep streaming at full rate under backpressure.
// Ports: clk/reset; in_data/in_valid (push, only when can_accept);
//        can_accept (slot2 empty); out_data/out_valid/out_bp (head token).
module li_skid_buffer_2slot
  import li_rr_merge_arbiter_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             can_accept,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_bp
);

  logic             slot1_valid;
  logic             slot2_valid;
  logic [Width-1:0] slot1_data;
  logic [Width-1:0] slot2_data;
  logic             pop;

  assign can_accept = ~slot2_valid;
  assign pop        = slot1_valid & ~out_bp;
  assign out_valid  = slot1_valid;
  assign out_data   = slot1_data;

  // Occupancy. A push never coincides with slot2 being full, because the
  // upstream only pushes while can_accept is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot1_valid <= 1'b0;
      slot2_valid <= 1'b0;
    end else if (in_valid && !pop) begin
      if (!slot1_valid) slot1_valid <= 1'b1;
      else              slot2_valid <= 1'b1;
    end else if (!in_valid && pop) begin
      if (slot2_valid) slot2_valid <= 1'b0;
      else             slot1_valid <= 1'b0;
    end
  end

  // Payload of an empty slot is don't-care, so data carries no reset.
  always_ff @(posedge clk) begin
    if (in_valid && (pop || !slot1_valid)) begin
      slot1_data <= in_data;
    end else if (in_valid) begin
      slot2_data <= in_data;
    end else if (pop && slot2_valid) begin
      slot1_data <= slot2_data;
    end
  end

endmodule

// File: rtl/li_rr_merge_arbiter.sv
// N-to-1 round-robin merge of valid/bp channels; multi-beat packets hold the
// grant until their last beat, output tagged with source index via a 2-slot buffer.
// Ports: clk/reset; in_data/in_valid/in_last/in_bp per channel;
//        out_data/out_idx/out_last/out_valid with downstream out_bp.
module li_rr_merge_arbiter
  import li_rr_merge_arbiter_pkg::*;
#(
  parameter int NumInputs = 4,
  parameter int Width     = 8,
  parameter int IdxWidth  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NumInputs*Width-1:0] in_data,
  input  logic [NumInputs-1:0]       in_valid,
  input  logic [NumInputs-1:0]       in_last,
  output logic [NumInputs-1:0]       in_bp,
  output logic [Width-1:0]           out_data,
  output logic [IdxWidth-1:0]        out_idx,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_bp
);

  localparam int PayloadWidth = Width + IdxWidth + 1;
  localparam int PosWidth     = IdxWidth + 1;

  if (clog2(NumInputs) != IdxWidth) begin : g_idx_width_check
    $error("IdxWidth must equal clog2(NumInputs)");
  end

  arb_state_t              state;
  logic [IdxWidth-1:0]     rr_ptr;
  logic [IdxWidth-1:0]     lock_idx;
  logic [IdxWidth-1:0]     scan_idx;
  logic                    scan_valid;
  logic [PosWidth-1:0]     pos;
  logic [IdxWidth-1:0]     grant;
  logic                    grant_valid;
  logic                    grant_last;
  logic [Width-1:0]        grant_data;
  logic                    can_accept;
  logic                    take_ok;
  logic                    accept;
  logic [PayloadWidth-1:0] buf_out;

  // Rotating priority scan: walk from the farthest offset down to offset 0
  // so the valid requester closest to rr_ptr wins.
  always_comb begin
    scan_valid = 1'b0;
    scan_idx   = '0;
    pos        = '0;
    for (int k = NumInputs - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + PosWidth'(k);
      if (pos >= PosWidth'(NumInputs)) pos = pos - PosWidth'(NumInputs);
      if (in_valid[pos[IdxWidth-1:0]]) begin
        scan_valid = 1'b1;
        scan_idx   = pos[IdxWidth-1:0];
      end
    end
  end

  // A locked packet keeps its grant even while its source has no token.
  assign grant       = (state == ARB_LOCKED) ? lock_idx : scan_idx;
  assign grant_valid = (state == ARB_LOCKED) | scan_valid;
  assign take_ok     = can_accept & grant_valid & ~reset;
  assign accept      = take_ok & in_valid[grant];
  assign grant_last  = in_last[grant];
  assign grant_data  = in_data[int'(grant)*Width +: Width];

  for (genvar i = 0; i < NumInputs; i++) begin : g_bp
    assign in_bp[i] = ~(take_ok && (grant == IdxWidth'(i)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else if (accept) begin
      if (grant_last) begin
        state  <= ARB_IDLE;
        rr_ptr <= (grant == IdxWidth'(NumInputs - 1)) ? '0 : grant + 1'b1;
      end else begin
        state    <= ARB_LOCKED;
        lock_idx <= grant;
      end
    end
  end

  li_skid_buffer_2slot #(
    .Width(PayloadWidth)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({grant_last, grant, grant_data}),
    .in_valid  (accept),
    .can_accept(can_accept),
    .out_data  (buf_out),
    .out_valid (out_valid),
    .out_bp    (out_bp)
  );

  assign {out_last, out_idx, out_data} = buf_out;

endmodule

// File: tb/tb_li_rr_merge_arbiter.sv
// Testbench for li_rr_merge_arbiter: cycle table for reset, rotation and
// multi-beat locking, hand sequences for backpressure, stalled lock and
// mid-packet reset, then random traffic against a token-queue model.
module tb_li_rr_merge_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_bp;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_idx;
  logic           out_last;
  logic           out_valid;
  logic           out_bp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  li_rr_merge_arbiter #(.NumInputs(N), .Width(W), .IdxWidth(IW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_bp(in_bp),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_bp(out_bp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic v, input logic l, input logic [7:0] d);
    in_valid[ch]         = v;
    in_last[ch]          = l;
    in_data[ch*W +: W]   = d;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = '0;
    in_last  = '0;
    out_bp   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Cycle table: inputs applied after a posedge, outputs checked at negedge.
  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       obp;
    logic       chk_out;
    logic [3:0] exp_bp;
    logic       exp_ov;
    logic [1:0] exp_idx;
    logic       exp_last;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic [3:0] vld, logic [3:0] lst, logic obp,
                              logic chk_out, logic [3:0] exp_bp, logic exp_ov,
                              logic [1:0] exp_idx, logic exp_last);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.obp = obp; v.chk_out = chk_out;
    v.exp_bp = exp_bp; v.exp_ov = exp_ov; v.exp_idx = exp_idx; v.exp_last = exp_last;
    return v;
  endfunction

  // Random-phase reference: queue of buffered tokens, lock owner, pointer.
  typedef struct {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } tok_t;

  tok_t       mq[$];
  int         lock_ch;
  int         ptr;
  int         open_src;
  int         beats_left[N];
  logic [7:0] dcur[N];
  logic       lcur[N];

  int         a_seq;
  logic [7:0] got[$];

  task automatic next_token(input int ch);
    if (beats_left[ch] == 0) beats_left[ch] = $urandom_range(1, 3);
    dcur[ch] = 8'($urandom);
    lcur[ch] = (beats_left[ch] == 1);
    beats_left[ch]--;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   g;
    logic [3:0] exp_bp;
    logic acc;
    tok_t t;

    // ---- Reset behaviour and first grant ----
    reset  = 1'b1;
    out_bp = 1'b0;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'hC0 | i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t1_reset_in_bp", 32'(in_bp), 32'hF);
      if (c > 0) chk("t1_reset_out_valid", 32'(out_valid), 32'h0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("t1_first_grant_bp", 32'(in_bp), 32'hE);
    chk("t1_first_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;

    // ---- Table: rotation of single beats, then a 3-beat locked packet ----
    vt.push_back(mk(1, 4'b1111, 4'b1111, 0, 0, 4'b1111, 0, 0, 0));
    vt.push_back(mk(1, 4'b1111, 4'b1111, 0, 1, 4'b1111, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 4'b1110, 0, 0, 0));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 4'b1101, 1, 0, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 4'b1011, 1, 1, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 4'b0111, 1, 2, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 4'b1110, 1, 3, 1));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 4'b1101, 1, 0, 1));
    vt.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 4'b1111, 0, 0, 0));
    vt.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 4'b1111, 0, 0, 0));
    vt.push_back(mk(0, 4'b0110, 4'b0100, 0, 1, 4'b1101, 0, 0, 0));
    vt.push_back(mk(0, 4'b0110, 4'b0100, 0, 1, 4'b1101, 1, 1, 0));
    vt.push_back(mk(0, 4'b0110, 4'b0110, 0, 1, 4'b1101, 1, 1, 0));
    vt.push_back(mk(0, 4'b0100, 4'b0100, 0, 1, 4'b1011, 1, 1, 1));
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b1111, 1, 2, 1));
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 4'b1111, 0, 0, 0));
    foreach (vt[r]) begin
      reset    = vt[r].rst;
      in_valid = vt[r].vld;
      in_last  = vt[r].lst;
      out_bp   = vt[r].obp;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_bp", r), 32'(in_bp), 32'(vt[r].exp_bp));
      if (vt[r].chk_out) begin
        chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(vt[r].exp_ov));
        if (vt[r].exp_ov) begin
          chk($sformatf("tbl%0d_out_idx", r), 32'(out_idx), 32'(vt[r].exp_idx));
          chk($sformatf("tbl%0d_out_last", r), 32'(out_last), 32'(vt[r].exp_last));
          chk($sformatf("tbl%0d_out_data", r), 32'(out_data), 32'(8'hC0 | vt[r].exp_idx));
        end
      end
      @(posedge clk); #1;
    end

    // ---- Downstream stall: buffer takes exactly two tokens ----
    do_reset();
    a_seq = 0;
    got.delete();
    for (int c = 0; c < 5; c++) begin
      out_bp = 1'b1;
      set_ch(0, 1'b1, 1'b1, 8'(8'hA1 + a_seq));
      @(negedge clk);
      if (in_valid[0] && !in_bp[0]) a_seq++;
      @(posedge clk); #1;
    end
    chk("t4_accepted_under_bp", 32'(a_seq), 32'd2);
    chk("t4_in_bp0_full", 32'(in_bp[0]), 32'h1);
    out_bp = 1'b0;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      if (a_seq < 3) set_ch(0, 1'b1, 1'b1, 8'(8'hA1 + a_seq));
      else           in_valid[0] = 1'b0;
      @(negedge clk);
      if (out_valid) got.push_back(out_data);
      if (in_valid[0] && !in_bp[0]) a_seq++;
      @(posedge clk); #1;
    end
    chk("t4_out_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("t4_out_data%0d", k), 32'(got[k]), 32'(8'hA1 + k));
    in_valid = '0;

    // ---- Locked source stalls; others must wait ----
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 1'b0, 1'b0, 8'(8'h10 * (i + 1)));
    set_ch(3, 1'b1, 1'b0, 8'h31);
    @(negedge clk);
    chk("t5_lock_grant_bp", 32'(in_bp), 32'h7);
    @(posedge clk); #1;
    in_valid = 4'b0111;
    in_last  = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5_hold_bp%0d", c), 32'(in_bp), 32'h7);
      if (c == 0) begin
        chk("t5_beat1_valid", 32'(out_valid), 32'h1);
        chk("t5_beat1_tok", 32'({out_idx, out_data}), 32'({2'd3, 8'h31}));
      end
      @(posedge clk); #1;
    end
    set_ch(3, 1'b1, 1'b1, 8'h32);
    @(negedge clk);
    chk("t5_resume_bp", 32'(in_bp), 32'h7);
    @(posedge clk); #1;
    in_valid[3] = 1'b0;
    @(negedge clk);
    chk("t5_beat2_valid", 32'(out_valid), 32'h1);
    chk("t5_beat2_tok", 32'({out_last, out_idx, out_data}), 32'({1'b1, 2'd3, 8'h32}));
    chk("t5_next_grant_ch0", 32'(in_bp), 32'hE);
    @(posedge clk); #1;

    // ---- Reset with full buffer and lock held ----
    do_reset();
    set_ch(2, 1'b1, 1'b1, 8'h22);
    @(negedge clk);
    chk("t6_ch2_grant", 32'(in_bp), 32'hB);
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    out_bp      = 1'b1;
    set_ch(0, 1'b1, 1'b0, 8'h01);
    @(negedge clk);
    chk("t6_ch0_grant", 32'(in_bp), 32'hE);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_full_bp", 32'(in_bp), 32'hF);
    chk("t6_head_idx", 32'({out_valid, out_idx}), 32'({1'b1, 2'd2}));
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_reset_out_valid", 32'(out_valid), 32'h0);
    chk("t6_reset_in_bp", 32'(in_bp), 32'hF);
    @(posedge clk); #1;
    reset    = 1'b0;
    out_bp   = 1'b0;
    in_valid = 4'b1110;
    in_last  = 4'b1110;
    @(negedge clk);
    chk("t6_after_reset_grant", 32'(in_bp), 32'hD);
    chk("t6_after_reset_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;

    // ---- Random traffic against the token-queue model ----
    do_reset();
    mq.delete();
    lock_ch  = -1;
    ptr      = 0;
    open_src = -1;
    for (int i = 0; i < N; i++) begin
      beats_left[i] = 0;
      next_token(i);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        in_valid[i]        = ($urandom_range(0, 99) < 60);
        in_last[i]         = lcur[i];
        in_data[i*W +: W]  = dcur[i];
      end
      out_bp = ($urandom_range(0, 99) < 30);
      @(negedge clk);

      g = -1;
      if (lock_ch >= 0) g = lock_ch;
      else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && in_valid[(ptr + k) % N]) g = (ptr + k) % N;
        end
      end
      exp_bp = 4'hF;
      if (!reset && g >= 0 && mq.size() < 2) exp_bp[g] = 1'b0;
      chk("rnd_in_bp", 32'(in_bp), 32'(exp_bp));
      chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0 && out_valid)
        chk("rnd_out_tok", 32'({out_last, out_idx, out_data}),
            32'({mq[0].l, mq[0].i, mq[0].d}));
      if (out_valid && !out_bp) begin
        if (open_src >= 0) chk("rnd_atomic", 32'(out_idx), 32'(open_src));
        open_src = out_last ? -1 : int'(out_idx);
      end

      if (reset) begin
        mq.delete();
        lock_ch  = -1;
        ptr      = 0;
        open_src = -1;
      end else begin
        acc = (g >= 0) && (mq.size() < 2) && in_valid[g];
        if (mq.size() > 0 && !out_bp) void'(mq.pop_front());
        if (acc) begin
          t.d = dcur[g];
          t.i = 2'(g);
          t.l = lcur[g];
          mq.push_back(t);
          if (lcur[g]) begin
            lock_ch = -1;
            ptr     = (g + 1) % N;
          end else begin
            lock_ch = g;
          end
          next_token(g);
        end
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
